phase_cycle_ctrl: RTL and testbench

Sequences the 2-bit Gray-coded RF phase fed to the QPSK modulator during NMR pulse programs, implementing phase cycling across scans. Holds a programmable phase table indexed by cycle step and pulse number, serves a phase on each pulser request, and advances the cycle step at each scan end. Sits between the pulse sequencer and the QPSK modulator; an optional receiver-phase output drives the acquisition path.

---
 rtl/phase_cycle_pkg.sv | 26 ++
 rtl/phase_table_ram.sv | 42 ++++
 rtl/phase_cycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_phase_cycle_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/phase_cycle_pkg.sv
// phase_cycle_pkg: definitions shared by the phase-cycling controller.
//   - State encodings as legacy-compatible constants, plus a typed enum
//     built from those constants.
//   - Phase quadrant constants PH_0 / PH_90 / PH_180 / PH_270.
//   - quad_to_gray(): maps a quadrant to the 2-bit Gray code the QPSK
//     modulator expects (0->00, 1->01, 2->11, 3->10).
package phase_cycle_pkg;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = S_IDLE,
    ST_SCAN = S_SCAN
  } state_e;

  localparam logic [1:0] PH_0   = 2'd0;
  localparam logic [1:0] PH_90  = 2'd1;
  localparam logic [1:0] PH_180 = 2'd2;
  localparam logic [1:0] PH_270 = 2'd3;

  function automatic logic [1:0] quad_to_gray(input logic [1:0] q);
    return {q[1], q[1] ^ q[0]};
  endfunction

endpackage

// File: rtl/phase_table_ram.sv
// phase_table_ram: N_STEPS x N_PULSES x 2-bit phase register file.
//   clk        in  write clock
//   we_i       in  write strobe
//   wstep_i    in  write row (cycle step)
//   wpulse_i   in  write column (pulse number)
//   wdata_i    in  phase quadrant to store
//   rstep_i    in  read row
//   rpulse_i   in  read column
//   rdata_o    out stored quadrant (combinational read, 00 if out of range)
// Contents are not reset.
module phase_table_ram #(
  parameter int unsigned N_STEPS  = 16,
  parameter int unsigned N_PULSES = 4,
  parameter int unsigned SW       = 4,
  parameter int unsigned PW       = 2
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [SW-1:0] wstep_i,
  input  logic [PW-1:0] wpulse_i,
  input  logic [1:0]    wdata_i,
  input  logic [SW-1:0] rstep_i,
  input  logic [PW-1:0] rpulse_i,
  output logic [1:0]    rdata_o
);

  logic [1:0] mem_q [N_STEPS][N_PULSES];

  always_ff @(posedge clk) begin
    if (we_i && (32'(wstep_i) < N_STEPS) && (32'(wpulse_i) < N_PULSES)) begin
      mem_q[wstep_i][wpulse_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if ((32'(rstep_i) < N_STEPS) && (32'(rpulse_i) < N_PULSES)) begin
      rdata_o = mem_q[rstep_i][rpulse_i];
    end
  end

endmodule

// File: rtl/phase_cycle_ctrl.sv
// phase_cycle_ctrl: serves Gray-coded RF phases to the QPSK modulator from a
// programmable phase table indexed by {cycle step, pulse number}, advancing
// the cycle step at every scan end.
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       low forces IDLE
//   seq_start    begin a scan sequence at step 0 (IDLE only)
//   pulse_req    request phase for pulse_idx (SCAN only)
//   pulse_idx    pulse number; one bit wider than the column index so that
//                out-of-range requests can reach the error path
//   scan_end     advance the cycle step (SCAN only)
//   cycle_len    active cycle length, clamped to 1..N_STEPS
//   cfg_we/cfg_addr/cfg_wdata  table write {step, pulse}, IDLE only
//   cfg_rx_sel   (PHASE_CYCLE_RX_EN only) selects the receiver-phase table
//   RF_phase     Gray-coded phase, registered
//   phase_valid  one-cycle strobe with each served phase
//   rx_phase     Gray-coded receiver phase for the current step
//   step_idx     current cycle step
//   busy         high in SCAN
//   err          one-cycle strobe on rejected write or bad pulse_idx
// Optional feature macro: PHASE_CYCLE_RX_EN (receiver-phase table).
module phase_cycle_ctrl
  import phase_cycle_pkg::*;
#(
  parameter int unsigned N_PULSES = 4,
  parameter int unsigned N_STEPS  = 16,
  localparam int unsigned SW      = (N_STEPS  > 1) ? $clog2(N_STEPS)  : 1,
  localparam int unsigned PW      = (N_PULSES > 1) ? $clog2(N_PULSES) : 1,
  localparam int unsigned PIDX_W  = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              seq_start,
  input  logic              pulse_req,
  input  logic [PIDX_W-1:0] pulse_idx,
  input  logic              scan_end,
  input  logic [SW:0]       cycle_len,
  input  logic              cfg_we,
  input  logic [SW+PW-1:0]  cfg_addr,
  input  logic [1:0]        cfg_wdata,
`ifdef PHASE_CYCLE_RX_EN
  input  logic              cfg_rx_sel,
`endif
  output logic [1:0]        RF_phase,
  output logic              phase_valid,
  output logic [1:0]        rx_phase,
  output logic [SW-1:0]     step_idx,
  output logic              busy,
  output logic              err
);

  localparam logic [PIDX_W-1:0] NP_L = PIDX_W'(N_PULSES);
  localparam logic [SW:0]       NS_L = (SW+1)'(N_STEPS);

  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [1:0]    rf_q, rf_d;
  logic          pv_q, pv_d;
  logic          err_q, err_d;

  logic          tbl_we;
  logic [1:0]    tbl_rdata;
  logic [SW-1:0] wr_step;
  logic [PW-1:0] wr_pulse;
  logic          wr_pulse_ok;
  logic          rx_sel;
  logic [SW:0]   eff_len;
  logic [SW:0]   step_inc;
  logic          idx_bad;

  assign wr_step     = cfg_addr[SW+PW-1:PW];
  assign wr_pulse    = cfg_addr[PW-1:0];
  assign wr_pulse_ok = ({1'b0, wr_pulse} < NP_L);
  assign idx_bad     = (pulse_idx >= NP_L);

`ifdef PHASE_CYCLE_RX_EN
  // With a power-of-two column count every pulse code is a real column, so
  // the rx table needs its own select; otherwise the unused all-ones code is used.
  localparam bit POW2 = (N_PULSES == (1 << PW));
  assign rx_sel = POW2 ? cfg_rx_sel : (wr_pulse == '1);
`else
  assign rx_sel = 1'b0;
`endif

  always_comb begin
    eff_len = cycle_len;
    if (cycle_len == '0) begin
      eff_len = {{SW{1'b0}}, 1'b1};
    end else if (cycle_len > NS_L) begin
      eff_len = NS_L;
    end
  end

  assign step_inc = {1'b0, step_q} + {{SW{1'b0}}, 1'b1};

  phase_table_ram #(
    .N_STEPS  (N_STEPS),
    .N_PULSES (N_PULSES),
    .SW       (SW),
    .PW       (PW)
  ) u_table (
    .clk      (clk),
    .we_i     (tbl_we),
    .wstep_i  (wr_step),
    .wpulse_i (wr_pulse),
    .wdata_i  (cfg_wdata),
    .rstep_i  (step_q),
    .rpulse_i (pulse_idx[PW-1:0]),
    .rdata_o  (tbl_rdata)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rf_d    = rf_q;
    pv_d    = 1'b0;
    err_d   = 1'b0;
    tbl_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          if (!rx_sel) begin
            if (wr_pulse_ok) tbl_we = 1'b1;
            else             err_d  = 1'b1;
          end
        end
        if (seq_start && enable) begin
          state_d = ST_SCAN;
          step_d  = '0;
        end
      end
      ST_SCAN: begin
        if (cfg_we) err_d = 1'b1;
        if (!enable) begin
          state_d = ST_IDLE;
          step_d  = '0;
          rf_d    = PH_0;
        end else begin
          if (pulse_req) begin
            pv_d = 1'b1;
            if (idx_bad) begin
              rf_d  = PH_0;
              err_d = 1'b1;
            end else begin
              rf_d = quad_to_gray(tbl_rdata);
            end
          end
          // >= rather than == so a cycle_len shortened mid-scan still wraps.
          if (scan_end) begin
            step_d = (step_inc >= eff_len) ? '0 : step_inc[SW-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      rf_q    <= PH_0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rf_q    <= rf_d;
      pv_q    <= pv_d;
      err_q   <= err_d;
    end
  end

`ifdef PHASE_CYCLE_RX_EN
  logic [1:0] rx_tbl_q [N_STEPS];
  logic [1:0] rx_q;

  always_ff @(posedge clk) begin
    if (cfg_we && rx_sel && (state_q == ST_IDLE) && (32'(wr_step) < N_STEPS)) begin
      rx_tbl_q[wr_step] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_q <= PH_0;
    else        rx_q <= quad_to_gray(rx_tbl_q[step_d]);
  end

  assign rx_phase = rx_q;
`else
  assign rx_phase = PH_0;
`endif

  assign RF_phase    = rf_q;
  assign phase_valid = pv_q;
  assign step_idx    = step_q;
  assign busy        = (state_q == ST_SCAN);
  assign err         = err_q;

endmodule

// File: tb/tb_phase_cycle_ctrl.sv
module tb_phase_cycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       seq_start;
  logic       pulse_req;
  logic [2:0] pulse_idx;
  logic       scan_end;
  logic [4:0] cycle_len;
  logic       cfg_we;
  logic [5:0] cfg_addr;
  logic [1:0] cfg_wdata;
  logic [1:0] RF_phase;
  logic       phase_valid;
  logic [1:0] rx_phase;
  logic [3:0] step_idx;
  logic       busy;
  logic       err;

  int vecs = 0;
  int errs = 0;

  phase_cycle_ctrl #(
    .N_PULSES (4),
    .N_STEPS  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .seq_start   (seq_start),
    .pulse_req   (pulse_req),
    .pulse_idx   (pulse_idx),
    .scan_end    (scan_end),
    .cycle_len   (cycle_len),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
`ifdef PHASE_CYCLE_RX_EN
    .cfg_rx_sel  (1'b0),
`endif
    .RF_phase    (RF_phase),
    .phase_valid (phase_valid),
    .rx_phase    (rx_phase),
    .step_idx    (step_idx),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input int p, input int q);
    cfg_we    = 1'b1;
    cfg_addr  = 6'((s << 2) | p);
    cfg_wdata = 2'(q);
    cyc();
    cfg_we    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    vecs++; if (RF_phase !== 2'b00) begin errs++; $display("FAIL reset_rf got %b want 00", RF_phase); end
    vecs++; if (phase_valid !== 1'b0) begin errs++; $display("FAIL reset_pv got %b want 0", phase_valid); end
    vecs++; if (rx_phase !== 2'b00) begin errs++; $display("FAIL reset_rx got %b want 00", rx_phase); end
    vecs++; if (step_idx !== 4'd0) begin errs++; $display("FAIL reset_step got %0d want 0", step_idx); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", err); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    logic [1:0] exp [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) wr(0, i, i);
    seq_start = 1'b1;
    cyc();
    seq_start = 1'b0;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL start_busy got %b want 1", busy); end
    vecs++; if (step_idx !== 4'd0) begin errs++; $display("FAIL start_step got %0d want 0", step_idx); end
    for (int i = 0; i < 4; i++) begin
      pulse_req = 1'b1;
      pulse_idx = 3'(i);
      cyc();
      pulse_req = 1'b0;
      vecs++; if (RF_phase !== exp[i]) begin errs++; $display("FAIL basic_rf%0d got %b want %b", i, RF_phase, exp[i]); end
      vecs++; if (phase_valid !== 1'b1) begin errs++; $display("FAIL basic_pv%0d got %b want 1", i, phase_valid); end
    end
    cyc();
    vecs++; if (phase_valid !== 1'b0) begin errs++; $display("FAIL hold_pv got %b want 0", phase_valid); end
    vecs++; if (RF_phase !== 2'b10) begin errs++; $display("FAIL hold_rf got %b want 10", RF_phase); end
  endtask

  task automatic test_cycle();
    logic [1:0] exp [6] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
    int quads [4] = '{0, 2, 1, 3};
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    for (int s = 0; s < 4; s++) wr(s, 0, quads[s]);
    cycle_len = 5'd4;
    seq_start = 1'b1;
    cyc();
    seq_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse_req = 1'b1;
      pulse_idx = 3'd0;
      cyc();
      pulse_req = 1'b0;
      vecs++; if (RF_phase !== exp[i]) begin errs++; $display("FAIL cycle_rf%0d got %b want %b", i, RF_phase, exp[i]); end
      scan_end = 1'b1;
      cyc();
      scan_end = 1'b0;
      vecs++; if (step_idx !== 4'((i + 1) % 4)) begin errs++; $display("FAIL cycle_step%0d got %0d want %0d", i, step_idx, (i + 1) % 4); end
    end
  endtask

  task automatic test_same_cycle();
    // Step is 2 here; step 2 column 0 holds quadrant 1.
    pulse_req = 1'b1;
    pulse_idx = 3'd0;
    scan_end  = 1'b1;
    cyc();
    pulse_req = 1'b0;
    scan_end  = 1'b0;
    vecs++; if (RF_phase !== 2'b01) begin errs++; $display("FAIL same_rf got %b want 01", RF_phase); end
    vecs++; if (phase_valid !== 1'b1) begin errs++; $display("FAIL same_pv got %b want 1", phase_valid); end
    vecs++; if (step_idx !== 4'd3) begin errs++; $display("FAIL same_step got %0d want 3", step_idx); end
  endtask

  task automatic test_scan_errors();
    wr(0, 3, 0);
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL scanwr_err got %b want 1", err); end
    pulse_req = 1'b1;
    pulse_idx = 3'd5;
    cyc();
    pulse_req = 1'b0;
    vecs++; if (RF_phase !== 2'b00) begin errs++; $display("FAIL badidx_rf got %b want 00", RF_phase); end
    vecs++; if (phase_valid !== 1'b1) begin errs++; $display("FAIL badidx_pv got %b want 1", phase_valid); end
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL badidx_err got %b want 1", err); end
    pulse_req = 1'b1;
    pulse_idx = 3'd0;
    cyc();
    pulse_req = 1'b0;
    vecs++; if (RF_phase !== 2'b10) begin errs++; $display("FAIL step3_rf got %b want 10", RF_phase); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL step3_err got %b want 0", err); end
    enable = 1'b0;
    cyc();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL disable_busy got %b want 0", busy); end
    vecs++; if (step_idx !== 4'd0) begin errs++; $display("FAIL disable_step got %0d want 0", step_idx); end
    vecs++; if (RF_phase !== 2'b00) begin errs++; $display("FAIL disable_rf got %b want 00", RF_phase); end
    enable    = 1'b1;
    seq_start = 1'b1;
    cyc();
    seq_start = 1'b0;
    pulse_req = 1'b1;
    pulse_idx = 3'd3;
    cyc();
    pulse_req = 1'b0;
    vecs++; if (RF_phase !== 2'b10) begin errs++; $display("FAIL readback_rf got %b want 10", RF_phase); end
  endtask

  task automatic test_async_reset();
    scan_end = 1'b1;
    cyc();
    scan_end  = 1'b0;
    pulse_req = 1'b1;
    pulse_idx = 3'd0;
    cyc();
    pulse_req = 1'b0;
    vecs++; if (RF_phase !== 2'b11) begin errs++; $display("FAIL prereset_rf got %b want 11", RF_phase); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (RF_phase !== 2'b00) begin errs++; $display("FAIL areset_rf got %b want 00", RF_phase); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL areset_busy got %b want 0", busy); end
    vecs++; if (step_idx !== 4'd0) begin errs++; $display("FAIL areset_step got %0d want 0", step_idx); end
    vecs++; if (phase_valid !== 1'b0) begin errs++; $display("FAIL areset_pv got %b want 0", phase_valid); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_zero_len();
    cycle_len = 5'd0;
    seq_start = 1'b1;
    cyc();
    seq_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      scan_end = 1'b1;
      cyc();
      scan_end = 1'b0;
      vecs++; if (step_idx !== 4'd0) begin errs++; $display("FAIL zerolen_step%0d got %0d want 0", i, step_idx); end
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL zerolen_busy%0d got %b want 1", i, busy); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    seq_start = 1'b0;
    pulse_req = 1'b0;
    pulse_idx = '0;
    scan_end  = 1'b0;
    cycle_len = 5'd16;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    test_reset();
    test_basic();
    test_cycle();
    test_same_cycle();
    test_scan_errors();
    test_async_reset();
    test_zero_len();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
